// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its consumers.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned XLEN    = 32;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched {instr, pc} entries; flush wins over a same-cycle push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     wdata_i,
  output fetch_entry_t     rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_i) begin
        r_mem[r_wptr] <= wdata_i;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (pop_i) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign rdata_o = r_mem[r_rptr];
  assign count_o = r_count;
  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CNT_W'(DEPTH));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && !flush_i && full_o));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && !flush_i && empty_o));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: sequential PC generation, credit-limited imem requests, in-order
// response buffering, and redirect handling that drops stale in-flight responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] instr_pc_next_o
);

  localparam int unsigned      CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]   CAP   = (CNT_W + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_resp_pc;
  logic [CNT_W-1:0] r_out;
  logic [CNT_W-1:0] r_discard;

  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic [CNT_W:0]   w_inflight;
  logic             w_req;
  logic             w_fire;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  logic [XLEN-1:0]  w_redirect_pc;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

  // Handshakes: an imem request counts only in a cycle with imem_req_o && imem_gnt_i
  // and may be withdrawn without a grant; an instruction transfers to decode in a
  // cycle with instr_valid_o && instr_ready_i, and the head is held while valid && !ready.
  assign w_inflight    = {1'b0, w_fifo_count} + {1'b0, r_out};
  assign w_req         = rst_ni && (w_inflight < CAP) && !redirect_i;
  assign w_fire        = w_req && imem_gnt_i;
  assign w_drop        = imem_rvalid_i && (r_discard != '0);
  assign w_push        = imem_rvalid_i && (r_discard == '0);
  assign w_pop         = instr_valid_o && instr_ready_i;
  assign w_redirect_pc = pc_align(redirect_pc_i);
  assign w_push_entry  = '{instr: imem_rdata_i, pc: r_resp_pc};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_out     <= '0;
      r_discard <= '0;
    end else if (redirect_i) begin
      // Everything still outstanding after this edge belongs to the old path.
      r_pc      <= w_redirect_pc;
      r_resp_pc <= w_redirect_pc;
      r_out     <= r_out - CNT_W'(imem_rvalid_i);
      r_discard <= r_out - CNT_W'(imem_rvalid_i);
    end else begin
      if (w_fire) begin
        r_pc <= r_pc + PC_STEP;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + PC_STEP;
      end
      if (w_drop) begin
        r_discard <= r_discard - CNT_W'(1);
      end
      r_out <= r_out + CNT_W'(w_fire) - CNT_W'(imem_rvalid_i);
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (redirect_i),
    .wdata_i (w_push_entry),
    .rdata_o (w_head),
    .count_o (w_fifo_count),
    .empty_o (w_fifo_empty),
    .full_o  (w_fifo_full)
  );

  assign imem_req_o      = w_req;
  assign imem_addr_o     = r_pc;
  assign instr_valid_o   = !w_fifo_empty && !redirect_i;
  assign instr_o         = w_head.instr;
  assign instr_pc_o      = w_head.pc;
  assign instr_pc_next_o = w_head.pc + PC_STEP;

  // Credit invariant: a full buffer implies no request is still outstanding.
  a_credit_cap: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_inflight <= CAP);
  a_full_no_out: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_fifo_full && (r_out != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a behavioural memory plus a PC-stream model
// that predicts requests, buffered instructions and redirect outcomes.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] HI_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc, instr_pc_next;
  logic        h_req, h_rvalid, h_valid;
  logic [31:0] h_addr, h_rdata, h_instr, h_pc, h_pc_next;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_gnt_i      (imem_gnt),
    .imem_rvalid_i   (imem_rvalid),
    .imem_rdata_i    (imem_rdata),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirect_pc),
    .instr_valid_o   (instr_valid),
    .instr_ready_i   (instr_ready),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .instr_pc_next_o (instr_pc_next)
  );

  // Second instance near the top of the address space: always granted, always ready.
  fetch_unit #(
    .RESET_PC   (HI_PC),
    .FIFO_DEPTH (DEPTH)
  ) u_hi (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .imem_req_o      (h_req),
    .imem_addr_o     (h_addr),
    .imem_gnt_i      (1'b1),
    .imem_rvalid_i   (h_rvalid),
    .imem_rdata_i    (h_rdata),
    .redirect_i      (1'b0),
    .redirect_pc_i   (32'h0),
    .instr_valid_o   (h_valid),
    .instr_ready_i   (1'b1),
    .instr_o         (h_instr),
    .instr_pc_o      (h_pc),
    .instr_pc_next_o (h_pc_next)
  );

  // ---------------- scoreboard / model state ----------------
  int          checks;
  int          errors;
  mreq_t       pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch;
  int          epoch;
  int          cyc;
  int          first_valid_cyc;
  int          grant_cnt;

  int unsigned gnt_pct, rdy_pct, red_pct, lat_min, lat_max;
  int          red_mode;
  logic [31:0] red_target;
  logic        red_fired;

  logic        cap_arm_addr, cap_arm_pc;
  logic [31:0] cap_addr, cap_pc;

  logic        h_pend;
  logic [31:0] h_pend_addr;
  logic [31:0] h_addr_log[$];
  logic [31:0] h_pc_log[$];
  logic [31:0] h_next_log[$];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    h_rvalid    = 1'b0;
    h_rdata     = 32'h0;
  endtask

  task automatic reset_model();
    pend_q.delete();
    exp_q.delete();
    exp_fetch       = 32'h0;
    cyc             = -1;
    first_valid_cyc = -1;
    grant_cnt       = 0;
    h_pend          = 1'b0;
    h_pend_addr     = 32'h0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_req"},     32'(imem_req), 32'd0);
    check_eq({pfx, "_addr"},    imem_addr, 32'h0);
    check_eq({pfx, "_valid"},   32'(instr_valid), 32'd0);
    check_eq({pfx, "_instr"},   instr, 32'h0);
    check_eq({pfx, "_pc"},      instr_pc, 32'h0);
    check_eq({pfx, "_pc_next"}, instr_pc_next, 32'd4);
    check_eq({pfx, "_hi_req"},  32'(h_req), 32'd0);
    check_eq({pfx, "_hi_addr"}, h_addr, HI_PC);
    check_eq({pfx, "_hi_next"}, h_pc_next, 32'd4);
  endtask

  task automatic arm_capture();
    cap_arm_addr = 1'b1;
    cap_arm_pc   = 1'b1;
    cap_addr     = 'x;
    cap_pc       = 'x;
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, then advance the model.
  task automatic step();
    logic        rv, red, rdy, gnt, exp_req, exp_valid;
    logic [31:0] tgt, head;
    mreq_t       m;
    @(negedge clk);
    cyc++;
    gnt = ($urandom_range(99) < gnt_pct);
    rdy = ($urandom_range(99) < rdy_pct);
    rv  = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    case (red_mode)
      1:       red = (pend_q.size() == 2) && (pend_q[0].epoch == epoch) && (pend_q[1].epoch == epoch);
      2:       red = rv && (exp_q.size() > 0);
      3:       red = 1'b1;
      default: red = ($urandom_range(999) < red_pct);
    endcase
    tgt = (red_mode != 0) ? red_target : $urandom();

    imem_gnt    = gnt;
    imem_rvalid = rv;
    imem_rdata  = rv ? data_of(pend_q[0].addr) : $urandom();
    redirect    = red;
    redirect_pc = tgt;
    instr_ready = rdy;
    h_rvalid    = h_pend;
    h_rdata     = h_pend ? data_of(h_pend_addr) : 32'h0;
    #1;

    exp_req = (exp_q.size() + pend_q.size() < DEPTH) && !red;
    check_eq("imem_req", 32'(imem_req), 32'(exp_req));
    if (imem_req && exp_req) check_eq("imem_addr", imem_addr, exp_fetch);
    exp_valid = (exp_q.size() > 0) && !red;
    check_eq("instr_valid", 32'(instr_valid), 32'(exp_valid));
    if (exp_valid && instr_valid) begin
      head = exp_q[0];
      check_eq("instr_pc", instr_pc, head);
      check_eq("instr", instr, data_of(head));
      check_eq("instr_pc_next", instr_pc_next, head + 32'd4);
    end

    if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (imem_req && gnt) begin
      grant_cnt++;
      if (cap_arm_addr) begin
        cap_addr     = imem_addr;
        cap_arm_addr = 1'b0;
      end
    end
    if (instr_valid && rdy && cap_arm_pc) begin
      cap_pc     = instr_pc;
      cap_arm_pc = 1'b0;
    end

    if (h_req && h_addr_log.size() < 3) h_addr_log.push_back(h_addr);
    if (h_valid && h_pc_log.size() < 3) begin
      h_pc_log.push_back(h_pc);
      h_next_log.push_back(h_pc_next);
      check_eq("hi_instr", h_instr, data_of(h_pc));
    end
    h_pend      = h_req;
    h_pend_addr = h_addr;

    if (red) begin
      if (rv) void'(pend_q.pop_front());
      exp_q.delete();
      epoch++;
      exp_fetch = tgt & 32'hFFFF_FFFC;
      red_fired = 1'b1;
      red_mode  = 0;
      arm_capture();
    end else begin
      if (exp_valid && rdy) void'(exp_q.pop_front());
      if (rv) begin
        m = pend_q.pop_front();
        if (m.epoch == epoch) exp_q.push_back(m.addr);
      end
      if (imem_req && gnt) begin
        pend_q.push_back('{addr: imem_addr, epoch: epoch,
                           due: cyc + int'($urandom_range(lat_max, lat_min))});
        exp_fetch += 32'd4;
      end
    end
  endtask

  task automatic set_knobs(input int unsigned g, input int unsigned r,
                           input int unsigned lmin, input int unsigned lmax,
                           input int unsigned rp);
    gnt_pct = g;
    rdy_pct = r;
    lat_min = lmin;
    lat_max = lmax;
    red_pct = rp;
  endtask

  task automatic run_directed_redirect(input string tag, input int mode, input logic [31:0] tgt);
    red_mode   = mode;
    red_target = tgt;
    red_fired  = 1'b0;
    for (int i = 0; i < 40 && !red_fired; i++) step();
    red_mode = 0;
    check_eq({tag, "_fired"}, 32'(red_fired), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    checks       = 0;
    errors       = 0;
    epoch        = 0;
    red_mode     = 0;
    red_target   = 32'h0;
    red_fired    = 1'b0;
    cap_arm_addr = 1'b0;
    cap_arm_pc   = 1'b0;
    cap_addr     = 32'h0;
    cap_pc       = 32'h0;
    rst_n        = 1'b0;
    drive_idle();
    reset_model();
    set_knobs(100, 0, 1, 1, 0);

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    release_reset();

    // Stall from reset: two grants fill the credit, then requests stop.
    arm_capture();
    repeat (10) step();
    check_eq("stall_grants", 32'(grant_cnt), 32'd2);
    check_eq("first_valid_cyc", 32'(first_valid_cyc), 32'd2);
    check_eq("stall_first_addr", cap_addr, 32'h0);

    set_knobs(100, 100, 1, 1, 0);
    repeat (20) step();
    check_eq("release_first_pc", cap_pc, 32'h0);

    if (h_addr_log.size() == 3 && h_pc_log.size() == 3) begin
      check_eq("hi_addr0", h_addr_log[0], 32'hFFFF_FFF8);
      check_eq("hi_addr1", h_addr_log[1], 32'hFFFF_FFFC);
      check_eq("hi_addr2", h_addr_log[2], 32'h0000_0000);
      check_eq("hi_pc0",   h_pc_log[0],   32'hFFFF_FFF8);
      check_eq("hi_pc1",   h_pc_log[1],   32'hFFFF_FFFC);
      check_eq("hi_pc2",   h_pc_log[2],   32'h0000_0000);
      check_eq("hi_next1", h_next_log[1], 32'h0000_0000);
    end else begin
      check_eq("hi_log_len", 32'(h_pc_log.size()), 32'd3);
    end

    // Redirect with two requests in flight at 3-cycle latency.
    set_knobs(100, 100, 3, 3, 0);
    run_directed_redirect("redir_100", 1, 32'h0000_0100);
    repeat (15) step();
    check_eq("redir_100_addr", cap_addr, 32'h0000_0100);
    check_eq("redir_100_pc", cap_pc, 32'h0000_0100);

    // Unaligned redirect target is word-aligned.
    set_knobs(100, 100, 1, 1, 0);
    run_directed_redirect("redir_203", 3, 32'h0000_0203);
    repeat (10) step();
    check_eq("redir_203_addr", cap_addr, 32'h0000_0200);
    check_eq("redir_203_pc", cap_pc, 32'h0000_0200);

    // Redirect in a cycle with a valid head and a returning response.
    run_directed_redirect("redir_same", 2, 32'h0000_0040);
    step();
    check_eq("redir_same_next_valid", 32'(instr_valid), 32'd0);
    repeat (10) step();
    check_eq("redir_same_pc", cap_pc, 32'h0000_0040);

    // Random traffic.
    set_knobs(60, 60, 1, 5, 15);
    repeat (3000) step();
    set_knobs(80, 20, 1, 3, 10);
    repeat (1000) step();

    // Fill the buffer, then reset asynchronously mid-cycle.
    set_knobs(100, 0, 1, 1, 0);
    for (int i = 0; i < 20 && exp_q.size() < DEPTH; i++) step();
    check_eq("full_before_reset", 32'(instr_valid), 32'd1);
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    reset_model();
    repeat (2) @(posedge clk);
    release_reset();
    arm_capture();
    set_knobs(100, 100, 1, 1, 0);
    repeat (20) step();
    check_eq("restart_addr", cap_addr, 32'h0);
    check_eq("restart_pc", cap_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
